// File: rtl/multi_lane_sync_fifo_pkg.sv
// Shared sizing and pointer helpers for the multi-lane synchronous FIFO.
package multi_lane_fifo_pkg;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Wraps at depth-1 so non-power-of-two depths stay in range.
  function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/multi_lane_sync_fifo_lane.sv
// One first-word-fall-through queue with occupancy count, threshold flags and flush.
module fifo_lane
  import multi_lane_fifo_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int WIDTH     = 8,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2,
  parameter int CW        = count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_w,
  output logic             ready_w,
  input  logic [WIDTH-1:0] data_w,
  output logic             valid_r,
  input  logic             ready_r,
  output logic [WIDTH-1:0] data_r,
  input  logic             flush,
  output logic [CW-1:0]    count,
  output logic             almost_full,
  output logic             almost_empty
);

  localparam int PW = ptr_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             full;
  logic             wr_fire;
  logic             rd_fire;

  assign full    = (count == CW'(DEPTH));
  // ready_w ignores ready_r on purpose: a full lane never takes a write, even while draining.
  assign ready_w = !full && !flush && !rst;
  assign valid_r = (count != '0) && !flush && !rst;
  assign wr_fire = valid_w && ready_w;
  assign rd_fire = valid_r && ready_r;

  assign data_r       = mem[rptr];
  assign almost_full  = (int'(count) >= AFULL_TH);
  assign almost_empty = (int'(count) <= AEMPTY_TH);

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wptr] <= data_w;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_fire) begin
        wptr <= PW'(next_ptr(32'(wptr), 32'(DEPTH)));
      end
      if (rd_fire) begin
        rptr <= PW'(next_ptr(32'(rptr), 32'(DEPTH)));
      end
      if (wr_fire && !rd_fire) begin
        count <= count + 1'b1;
      end else if (rd_fire && !wr_fire) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_lane_sync_fifo.sv
// LANES independent same-clock FIFOs sharing only the clock and reset.
module multi_lane_sync_fifo
  import multi_lane_fifo_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int DEPTH     = 16,
  parameter int WIDTH     = 8,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [LANES-1:0]                     valid_w,
  output logic [LANES-1:0]                     ready_w,
  input  logic [LANES*WIDTH-1:0]               data_w,
  output logic [LANES-1:0]                     valid_r,
  input  logic [LANES-1:0]                     ready_r,
  output logic [LANES*WIDTH-1:0]               data_r,
  input  logic [LANES-1:0]                     flush,
  output logic [LANES*count_width(DEPTH)-1:0]  count,
  output logic [LANES-1:0]                     almost_full,
  output logic [LANES-1:0]                     almost_empty
);

  localparam int CW = count_width(DEPTH);

  // Handshake: a write fires on valid_w & ready_w, a read on valid_r & ready_r, per lane.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    fifo_lane #(
      .DEPTH     (DEPTH),
      .WIDTH     (WIDTH),
      .AFULL_TH  (AFULL_TH),
      .AEMPTY_TH (AEMPTY_TH),
      .CW        (CW)
    ) u_lane (
      .clk          (clk),
      .rst          (rst),
      .valid_w      (valid_w[l]),
      .ready_w      (ready_w[l]),
      .data_w       (data_w[l*WIDTH +: WIDTH]),
      .valid_r      (valid_r[l]),
      .ready_r      (ready_r[l]),
      .data_r       (data_r[l*WIDTH +: WIDTH]),
      .flush        (flush[l]),
      .count        (count[l*CW +: CW]),
      .almost_full  (almost_full[l]),
      .almost_empty (almost_empty[l])
    );
  end

endmodule

// File: tb/tb_multi_lane_sync_fifo.sv
// Bench for multi_lane_sync_fifo: vector table, corner sequences and a queue-model random run.
module tb_multi_lane_sync_fifo;

  localparam int LANES = 4;
  localparam int DEPTH = 16;
  localparam int WIDTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int D5    = 5;
  localparam int CW5   = $clog2(D5 + 1);

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [LANES-1:0]       valid_w = '0, ready_r = '0, flush = '0;
  logic [LANES-1:0]       ready_w, valid_r, almost_full, almost_empty;
  logic [LANES*WIDTH-1:0] data_w = '0, data_r;
  logic [LANES*CW-1:0]    count;

  logic [0:0]       valid_w5 = '0, ready_r5 = '0, flush5 = '0;
  logic [0:0]       ready_w5, valid_r5, af5, ae5;
  logic [WIDTH-1:0] data_w5 = '0, data_r5;
  logic [CW5-1:0]   count5;

  multi_lane_sync_fifo #(.LANES(LANES), .DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .valid_w(valid_w), .ready_w(ready_w), .data_w(data_w),
    .valid_r(valid_r), .ready_r(ready_r), .data_r(data_r), .flush(flush),
    .count(count), .almost_full(almost_full), .almost_empty(almost_empty)
  );

  multi_lane_sync_fifo #(.LANES(1), .DEPTH(D5), .WIDTH(WIDTH)) dut5 (
    .clk(clk), .rst(rst), .valid_w(valid_w5), .ready_w(ready_w5), .data_w(data_w5),
    .valid_r(valid_r5), .ready_r(ready_r5), .data_r(data_r5), .flush(flush5),
    .count(count5), .almost_full(af5), .almost_empty(ae5)
  );

  // scoreboard
  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] exp_q [LANES][$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; valid_w = '0; ready_r = '0; flush = '0; data_w = '0;
    valid_w5 = '0; ready_r5 = '0; flush5 = '0;
    tick();
    tick();
    check("rst_ready_w", 32'(ready_w), 32'h0);
    check("rst_valid_r", 32'(valid_r), 32'h0);
    rst = 1'b0;
  endtask

  function automatic logic [CW-1:0] cnt(input int l);
    return count[l*CW +: CW];
  endfunction

  function automatic logic [WIDTH-1:0] dat(input int l);
    return data_r[l*WIDTH +: WIDTH];
  endfunction

  typedef struct {
    logic [LANES-1:0] vw;
    logic [LANES-1:0] rr;
    logic [WIDTH-1:0] dw0;
    int               c0;
    logic             rw0, vr0, af0, ae0;
    logic [WIDTH-1:0] dr0;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vec_t v;
    int pushed, popped, guard;
    bit wr_ok, rd_ok;

    // Fill lane 0 to full, one extra refused write, then drain with the write held.
    for (int i = 0; i < DEPTH; i++) begin
      v.vw = 4'b0001; v.rr = 4'b0000; v.dw0 = 8'(i + 1);
      v.c0 = i + 1; v.rw0 = (i + 1 < DEPTH); v.vr0 = 1'b1;
      v.af0 = (i + 1 >= DEPTH - 2); v.ae0 = (i + 1 <= 2); v.dr0 = 8'h01;
      vecs.push_back(v);
    end
    v.vw = 4'b0001; v.rr = 4'b0000; v.dw0 = 8'h11;
    v.c0 = 16; v.rw0 = 1'b0; v.vr0 = 1'b1; v.af0 = 1'b1; v.ae0 = 1'b0; v.dr0 = 8'h01;
    vecs.push_back(v);
    v.vw = 4'b0001; v.rr = 4'b0001; v.dw0 = 8'h11;
    v.c0 = 15; v.rw0 = 1'b1; v.dr0 = 8'h02;
    vecs.push_back(v);
    for (int k = 0; k < 4; k++) begin
      v.dw0 = 8'(8'h12 + k); v.c0 = 15; v.rw0 = 1'b1; v.dr0 = 8'(3 + k);
      vecs.push_back(v);
    end

    // Reset then idle defaults.
    do_reset();
    tick();
    for (int l = 0; l < LANES; l++) begin
      check("idle_valid_r", 32'(valid_r[l]), 32'h0);
      check("idle_ready_w", 32'(ready_w[l]), 32'h1);
      check("idle_count", 32'(cnt(l)), 32'h0);
      check("idle_aempty", 32'(almost_empty[l]), 32'h1);
      check("idle_afull", 32'(almost_full[l]), 32'h0);
    end

    // Table-driven fill / drain of lane 0.
    foreach (vecs[i]) begin
      valid_w = vecs[i].vw; ready_r = vecs[i].rr;
      data_w  = '0; data_w[WIDTH-1:0] = vecs[i].dw0;
      tick();
      check("vec_count0", 32'(cnt(0)), 32'(vecs[i].c0));
      check("vec_ready_w0", 32'(ready_w[0]), 32'(vecs[i].rw0));
      check("vec_valid_r0", 32'(valid_r[0]), 32'(vecs[i].vr0));
      check("vec_afull0", 32'(almost_full[0]), 32'(vecs[i].af0));
      check("vec_aempty0", 32'(almost_empty[0]), 32'(vecs[i].ae0));
      check("vec_data_r0", 32'(dat(0)), 32'(vecs[i].dr0));
      check("vec_other_lanes", 32'(count[LANES*CW-1:CW]), 32'h0);
    end

    // Depth-5 lane: 2 writes then 1 read, repeated; pointers wrap.
    do_reset();
    pushed = 0; popped = 0; guard = 0;
    while (popped < 7 && guard < 60) begin
      wr_ok = (guard % 3 != 2) && (pushed < 7);
      rd_ok = ((guard % 3 == 2) || (pushed == 7)) && (popped < pushed);
      valid_w5 = wr_ok; data_w5 = 8'(8'hA0 + pushed); ready_r5 = rd_ok;
      if (rd_ok) check("d5_data_r", 32'(data_r5), 32'(8'hA0 + popped));
      check("d5_valid_r", 32'(valid_r5), 32'(popped < pushed));
      tick();
      if (wr_ok) pushed++;
      if (rd_ok) popped++;
      check("d5_count", 32'(count5), 32'(pushed - popped));
      guard++;
    end
    valid_w5 = '0; ready_r5 = '0;
    check("d5_done", 32'(popped), 32'd7);

    // Flush lane 2 with a concurrent write; lane 1 must be untouched.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      valid_w = 4'b0100; data_w = '0;
      data_w[2*WIDTH +: WIDTH] = 8'(8'h30 + i);
      if (i < 2) begin
        valid_w[1] = 1'b1; data_w[WIDTH +: WIDTH] = 8'(8'h10 + i);
      end
      tick();
    end
    check("fl_pre_count2", 32'(cnt(2)), 32'd3);
    valid_w = 4'b0100; data_w = '0; data_w[2*WIDTH +: WIDTH] = 8'hEE; flush = 4'b0100;
    #1;
    check("fl_ready_w_gated", 32'(ready_w[2]), 32'h0);
    check("fl_valid_r_gated", 32'(valid_r[2]), 32'h0);
    tick();
    valid_w = '0; flush = '0;
    check("fl_count2", 32'(cnt(2)), 32'h0);
    check("fl_valid_r2", 32'(valid_r[2]), 32'h0);
    check("fl_count1", 32'(cnt(1)), 32'd2);
    check("fl_data1", 32'(dat(1)), 32'h10);
    tick();
    check("fl_write_dropped", 32'(cnt(2)), 32'h0);

    // Write latency on an empty lane, then reset mid-occupancy.
    valid_w = 4'b1000; data_w = '0; data_w[3*WIDTH +: WIDTH] = 8'h5A;
    #1;
    check("lat_no_bypass", 32'(valid_r[3]), 32'h0);
    tick();
    valid_w = '0;
    check("lat_valid_r", 32'(valid_r[3]), 32'h1);
    check("lat_data_r", 32'(dat(3)), 32'h5A);
    tick();
    rst = 1'b1;
    #1;
    check("lat_rst_valid_r", 32'(valid_r[3]), 32'h0);
    check("lat_rst_ready_w", 32'(ready_w[3]), 32'h0);
    tick();
    rst = 1'b0;
    #1;
    check("lat_rst_count", 32'(cnt(3)), 32'h0);
    check("lat_rst_valid_after", 32'(valid_r[3]), 32'h0);

    // Random traffic on all lanes against a queue model.
    do_reset();
    for (int l = 0; l < LANES; l++) exp_q[l].delete();
    for (int c = 0; c < 600; c++) begin
      bit exp_rw, exp_vr, rd, wr;
      valid_w = 4'($urandom_range(0, 15));
      ready_r = 4'($urandom_range(0, 15));
      flush   = '0;
      for (int l = 0; l < LANES; l++) flush[l] = ($urandom_range(0, 31) == 0);
      rst     = ($urandom_range(0, 199) == 0);
      data_w  = LANES*WIDTH'($urandom());
      #1;
      for (int l = 0; l < LANES; l++) begin
        int sz;
        sz = exp_q[l].size();
        exp_rw = !rst && !flush[l] && (sz < DEPTH);
        exp_vr = !rst && !flush[l] && (sz > 0);
        check("rnd_ready_w", 32'(ready_w[l]), 32'(exp_rw));
        check("rnd_valid_r", 32'(valid_r[l]), 32'(exp_vr));
        check("rnd_count", 32'(cnt(l)), 32'(sz));
        check("rnd_afull", 32'(almost_full[l]), 32'(sz >= DEPTH - 2));
        check("rnd_aempty", 32'(almost_empty[l]), 32'(sz <= 2));
        if (exp_vr) check("rnd_data_r", 32'(dat(l)), 32'(exp_q[l][0]));
        rd = exp_vr && ready_r[l];
        wr = exp_rw && valid_w[l];
        if (rst || flush[l]) exp_q[l].delete();
        else begin
          if (rd) void'(exp_q[l].pop_front());
          if (wr) exp_q[l].push_back(data_w[l*WIDTH +: WIDTH]);
        end
      end
      tick();
    end
    rst = 1'b0; valid_w = '0; ready_r = '0; flush = '0;

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
